// File: rtl/pwm_dac_pkg.sv
// Shared constants and helpers for the pwm_dac single-bit audio DAC.
// Optional build macro: PWMDAC_SIGMADELTA_EN (sigma-delta modulator).
package pwm_dac_pkg;

   localparam int          FRAME_LEN   = 256;
   localparam logic [7:0]  ACK_CNT     = 8'd254;
   localparam logic [7:0]  PRE_ACK_CNT = ACK_CNT - 8'd1;
   localparam logic [7:0]  LOAD_CNT    = 8'hff;
   localparam logic [7:0]  LEVEL_RESET = 8'h80;

   typedef logic [7:0] level_t;

   function automatic level_t to_offset(input logic [7:0] din);
      return din ^ 8'h80;
   endfunction

endpackage

// File: rtl/pwm_dac_frame_ctr.sv
// Free-running 256-clock frame counter with request and load strobes.
// din_ack is registered so it is high exactly while cnt == ACK_CNT.
module pwm_dac_frame_ctr
   import pwm_dac_pkg::*;
(
   input  logic       clk,
   input  logic       rst_an,
   output logic [7:0] cnt,
   output logic       ack,
   output logic       load
);

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         cnt <= 8'd0;
         ack <= 1'b0;
      end else begin
         cnt <= cnt + 8'd1;
         ack <= (cnt == PRE_ACK_CNT);
      end
   end

   // Load happens on the 255 -> 0 edge, one clock after the request.
   assign load = (cnt == LOAD_CNT);

endmodule

// File: rtl/pwm_dac.sv
// Single-bit audio DAC: one signed 8-bit sample per 256-clock frame.
// Define PWMDAC_SIGMADELTA_EN to use a first-order sigma-delta modulator.
module pwm_dac
   import pwm_dac_pkg::*;
(
   input  logic       clk,
   input  logic       rst_an,
   input  logic [7:0] din,
   output logic       din_ack,
   output logic       dacout
);

   logic [7:0] cnt;
   logic       load;
   level_t     level_q;

   pwm_dac_frame_ctr u_ctr (
      .clk    (clk),
      .rst_an (rst_an),
      .cnt    (cnt),
      .ack    (din_ack),
      .load   (load)
   );

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         level_q <= LEVEL_RESET;
      end else if (load) begin
         level_q <= to_offset(din);
      end
   end

`ifdef PWMDAC_SIGMADELTA_EN
   logic [8:0] acc;
   logic [8:0] sum;

   // Carry out of the 8-bit phase accumulator is the output bit.
   assign sum = {1'b0, acc[7:0]} + {1'b0, level_q};

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         acc    <= 9'd0;
         dacout <= 1'b0;
      end else begin
         acc    <= sum;
         dacout <= sum[8];
      end
   end
`else
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         dacout <= 1'b0;
      end else begin
         dacout <= (cnt < level_q);
      end
   end
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// Directed self-checking bench for pwm_dac (frame counts, ack timing, reset).
module tb_pwm_dac;
   import pwm_dac_pkg::*;

   logic       clk;
   logic       rst_an;
   logic [7:0] din;
   logic       din_ack;
   logic       dacout;

   int n_cmp;
   int n_bad;

   pwm_dac dut (
      .clk     (clk),
      .rst_an  (rst_an),
      .din     (din),
      .din_ack (din_ack),
      .dacout  (dacout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      int         highs;
      string      name;
   } vec_t;

   vec_t vecs[8];
   logic bits[FRAME_LEN];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the ack cycle.
   task automatic wait_ack(output bit ok);
      int n;
      n = 0;
      while (!din_ack && n < 600) begin
         @(negedge clk);
         n++;
      end
      ok = din_ack;
      if (!ok) chk("ack_timeout", 0, 1);
   endtask

   // Capture the 256 output bits produced from the frame just loaded.
   task automatic capture(output int highs);
      highs = 0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < FRAME_LEN; i++) begin
         @(negedge clk);
         bits[i] = dacout;
         highs += int'(dacout);
      end
   endtask

   task automatic frame(input logic [7:0] d, input int exp,
                        input string name);
      bit ok;
      int h;
      wait_ack(ok);
      if (!ok) return;
      din = d;
      capture(h);
      chk(name, h, exp);
   endtask

   // Hold reset, release, then check the first frame after release.
   task automatic reset_release(input string tag);
      int h;
      int ack_pos;
      int bad;
      bad = 0;
      rst_an = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (dacout !== 1'b0 || din_ack !== 1'b0) bad++;
      end
      chk({tag, "_held_outputs"}, bad, 0);
      rst_an = 1'b1;
      h = 0;
      ack_pos = -1;
      @(posedge clk);
      for (int i = 0; i < FRAME_LEN; i++) begin
         @(negedge clk);
         h += int'(dacout);
         if (din_ack && ack_pos < 0) ack_pos = i + 1;
      end
      chk({tag, "_first_ack_clk"}, ack_pos, 254);
      chk({tag, "_first_frame_highs"}, h, 128);
   endtask

   initial begin
      bit   ok;
      int   v;
      int   pulses;
      int   last;
      int   run;
      int   wide;
      int   h;
      int   bad;

      n_cmp = 0;
      n_bad = 0;
      din = 8'h00;
      rst_an = 1'b0;

      vecs[0] = '{8'h80,   0, "duty_min"};
      vecs[1] = '{8'h00, 128, "duty_zero"};
      vecs[2] = '{8'h7f, 255, "duty_max"};
      vecs[3] = '{8'hc0,  64, "duty_m64"};
      vecs[4] = '{8'h01, 129, "duty_p1"};
      vecs[5] = '{8'hff, 127, "duty_m1"};
      vecs[6] = '{8'h40, 192, "duty_p64"};
      vecs[7] = '{8'h81,   1, "duty_m127"};

      @(negedge clk);
      reset_release("por");

      foreach (vecs[i]) frame(vecs[i].d, vecs[i].highs, vecs[i].name);

      // Request spacing and width over 32 frames from cnt == 0.
      pulses = 0;
      last = -1;
      run = 0;
      wide = 0;
      for (int i = 0; i < 32 * FRAME_LEN; i++) begin
         @(negedge clk);
         if (din_ack) begin
            run++;
            if (run == 1) begin
               if (last >= 0) chk("ack_spacing", i - last, FRAME_LEN);
               last = i;
               pulses++;
            end
         end else begin
            if (run > 1) wide++;
            run = 0;
         end
      end
      chk("ack_pulses", pulses, 32);
      chk("ack_width", wide, 0);

      for (int k = 0; k < 64; k++) begin
         v = int'(127.0 * $sin(2.0 * 3.14159265358979 * (4.0 * k) / 256.0));
         frame(8'(v), v + 128, $sformatf("sine_k%0d", 4 * k));
      end

      // Mid-frame reset with level 200 loaded.
      frame(8'd72, 200, "pre_reset_l200");
      repeat (100) @(posedge clk);
      #1;
`ifndef PWMDAC_SIGMADELTA_EN
      chk("mid_dacout_before", int'(dacout), 1);
`endif
      din = 8'h00;
      rst_an = 1'b0;
      #1;
      chk("mid_dacout_async", int'(dacout), 0);
      chk("mid_ack_async", int'(din_ack), 0);
      reset_release("mid");

`ifdef PWMDAC_SIGMADELTA_EN
      frame(8'hc0, 64, "sd_m64_first");
      wait_ack(ok);
      if (ok) begin
         capture(h);
         chk("sd_m64_ones", h, 64);
         bad = 0;
         for (int i = 4; i < FRAME_LEN; i++)
            if (bits[i] !== bits[i-4]) bad++;
         chk("sd_m64_period4", bad, 0);
      end
      frame(8'h00, 128, "sd_zero_first");
      wait_ack(ok);
      if (ok) begin
         capture(h);
         bad = 0;
         for (int i = 1; i < FRAME_LEN; i++)
            if (bits[i] === bits[i-1]) bad++;
         chk("sd_zero_alternate", bad, 0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
